// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: FSM state, access owner
// and the width of the latency/starvation counters.
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_D    = 2'd2
    } owner_t;

    localparam int LAT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch requester, load/store requester and unified-memory
// signals. The arbiter takes the slave view; requesters and RAM take the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    if_req;
    logic [ADDR_WIDTH-1:0]   if_addr;
    logic                    if_gnt;
    logic                    if_rvalid;
    logic [DATA_WIDTH-1:0]   if_rdata;

    logic                    d_req;
    logic                    d_we;
    logic [ADDR_WIDTH-1:0]   d_addr;
    logic [DATA_WIDTH-1:0]   d_wdata;
    logic [DATA_WIDTH/8-1:0] d_wstrb;
    logic                    d_gnt;
    logic                    d_rvalid;
    logic [DATA_WIDTH-1:0]   d_rdata;

    logic                    mem_req;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [DATA_WIDTH-1:0]   mem_wdata;
    logic [DATA_WIDTH/8-1:0] mem_wstrb;
    logic [DATA_WIDTH-1:0]   mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_rdata
    );

endinterface

// File: rtl/mem_port_arbiter_lat.sv
// Tracks the single outstanding memory access: who owns it, whether it is a
// store, and when the fixed-latency response arrives.
module arb_latency_tracker
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       grant,
    input  owner_t     grant_owner,
    input  logic       grant_store,
    output arb_state_t state,
    output owner_t     owner,
    output logic       is_store,
    output logic       done
);

    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(MEM_LATENCY - 1);

    logic [LAT_W-1:0] lat_cnt;

    assign done = (state == WAIT) && (lat_cnt == LAT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= OWN_NONE;
            is_store <= 1'b0;
            lat_cnt  <= '0;
        end else if (grant) begin
            // a grant on the completion cycle restarts the count for the next access
            state    <= WAIT;
            owner    <= grant_owner;
            is_store <= grant_store;
            lat_cnt  <= '0;
        end else if (state == WAIT) begin
            if (done) begin
                state   <= IDLE;
                owner   <= OWN_NONE;
                lat_cnt <= '0;
            end else begin
                lat_cnt <= lat_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port RAM between instruction fetch and
// load/store; D has priority, IF is forced after STARVE_LIMIT consecutive losses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);

    localparam logic [LAT_W-1:0] STARVE_MAX = LAT_W'(STARVE_LIMIT);

    arb_state_t       state;
    owner_t           owner;
    logic             is_store;
    logic             done;
    logic [LAT_W-1:0] starve_cnt;
    logic             eligible;
    logic             if_win;
    logic             d_win;
    owner_t           grant_owner;

    // Grants are suppressed while reset is asserted so every output reads zero.
    always_comb begin
        eligible    = rst && ((state == IDLE) || done);
        if_win      = eligible && bus.if_req && (!bus.d_req || (starve_cnt == STARVE_MAX));
        d_win       = eligible && bus.d_req && !if_win;
        grant_owner = d_win ? OWN_D : (if_win ? OWN_IF : OWN_NONE);
    end

    always_comb begin
        bus.if_gnt    = if_win;
        bus.d_gnt     = d_win;
        bus.mem_req   = if_win || d_win;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_wstrb = '0;
        if (d_win) begin
            bus.mem_we    = bus.d_we;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
            bus.mem_wstrb = bus.d_we ? bus.d_wstrb : '0;
        end else if (if_win) begin
            bus.mem_addr  = bus.if_addr;
        end
    end

    always_comb begin
        bus.if_rvalid = done && (owner == OWN_IF);
        bus.d_rvalid  = done && (owner == OWN_D);
        bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
        bus.d_rdata   = (bus.d_rvalid && !is_store) ? bus.mem_rdata : '0;
    end

    // Counts D wins that IF had to sit through; any break in IF waiting clears it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (if_win) begin
            starve_cnt <= '0;
        end else if (d_win) begin
            if (!bus.if_req)
                starve_cnt <= '0;
            else if (starve_cnt != STARVE_MAX)
                starve_cnt <= starve_cnt + 1'b1;
        end
    end

    arb_latency_tracker #(
        .MEM_LATENCY (MEM_LATENCY)
    ) u_lat (
        .clk         (clk),
        .rst         (rst),
        .grant       (if_win || d_win),
        .grant_owner (grant_owner),
        .grant_store (d_win && bus.d_we),
        .state       (state),
        .owner       (owner),
        .is_store    (is_store),
        .done        (done)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter with a cycle-level
// reference model and per-requester response scoreboards.
module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SW   = DW / 8;
    localparam int LAT  = 2;
    localparam int SL   = 4;
    localparam logic [DW-1:0] MASK = 32'hA5A5_0000;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
    } d_item_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_port_arbiter #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .MEM_LATENCY  (LAT),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory model: returns addr ^ MASK LAT cycles after the request, junk otherwise.
    logic [AW-1:0] pipe_a [LAT];
    logic          pipe_v [LAT];
    logic [DW-1:0] junk;
    always @(posedge clk) begin
        pipe_a[0] <= bus.mem_addr;
        pipe_v[0] <= bus.mem_req;
        for (int i = 1; i < LAT; i++) begin
            pipe_a[i] <= pipe_a[i-1];
            pipe_v[i] <= pipe_v[i-1];
        end
        junk <= $urandom;
    end
    assign bus.mem_rdata = pipe_v[LAT-1] ? (pipe_a[LAT-1] ^ MASK) : junk;

    logic [AW-1:0] if_todo [$];
    d_item_t       d_todo  [$];
    logic [DW-1:0] if_exp  [$];
    logic [DW-1:0] d_exp   [$];
    int            g_cyc   [$];
    int            g_who   [$];

    int   n_cmp = 0;
    int   n_bad = 0;
    logic if_gnt_seen = 1'b0;
    logic d_gnt_seen  = 1'b0;

    task automatic cmp(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic d_item_t mk_d(input logic we, input logic [AW-1:0] a,
                                     input logic [DW-1:0] wd, input logic [SW-1:0] ws);
        d_item_t it;
        it.we = we; it.addr = a; it.wdata = wd; it.wstrb = ws;
        return it;
    endfunction

    // Requesters: hold until a grant was seen, then reissue from the todo queue.
    task automatic drive_cycle();
        d_item_t it;
        logic [AW-1:0] a;
        @(posedge clk);
        #1;
        if (bus.if_req && if_gnt_seen) bus.if_req = 1'b0;
        if (!bus.if_req && if_todo.size() > 0) begin
            a = if_todo.pop_front();
            bus.if_addr = a;
            bus.if_req  = 1'b1;
            if_exp.push_back(a ^ MASK);
        end else if (!bus.if_req) begin
            bus.if_addr = $urandom;
        end
        if (bus.d_req && d_gnt_seen) bus.d_req = 1'b0;
        if (!bus.d_req && d_todo.size() > 0) begin
            it = d_todo.pop_front();
            bus.d_we    = it.we;
            bus.d_addr  = it.addr;
            bus.d_wdata = it.wdata;
            bus.d_wstrb = it.wstrb;
            bus.d_req   = 1'b1;
            d_exp.push_back(it.we ? '0 : (it.addr ^ MASK));
        end else if (!bus.d_req) begin
            bus.d_we    = $urandom;
            bus.d_addr  = $urandom;
            bus.d_wdata = $urandom;
            bus.d_wstrb = $urandom;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((if_todo.size() > 0 || d_todo.size() > 0 || if_exp.size() > 0 ||
                d_exp.size() > 0 || bus.if_req || bus.d_req) && n < 300) begin
            drive_cycle();
            n++;
        end
        cmp({name, "_drained"}, 192'(n < 300), 192'(1));
        repeat (3) drive_cycle();
    endtask

    // Reference model: one access per LAT cycles, D first unless IF has waited SL grants.
    int cyc      = 0;
    int free_cyc = 0;
    int starve   = 0;
    int done_cyc = -1;
    int done_who = 0;

    always @(negedge clk) begin
        logic e_if, e_d, x_ifv, x_dv;
        cyc++;
        if_gnt_seen = bus.if_gnt;
        d_gnt_seen  = bus.d_gnt;
        if (!rst) begin
            cmp("rst_ctl", 192'({bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid,
                                 bus.mem_req, bus.mem_we}), 192'(0));
            cmp("rst_data", 192'({bus.if_rdata, bus.d_rdata, bus.mem_addr,
                                  bus.mem_wdata, bus.mem_wstrb}), 192'(0));
            if (done_who == 1 && done_cyc >= cyc && if_exp.size() > 0) void'(if_exp.pop_front());
            if (done_who == 2 && done_cyc >= cyc && d_exp.size() > 0)  void'(d_exp.pop_front());
            done_who = 0;
            done_cyc = -1;
            free_cyc = 0;
            starve   = 0;
        end else begin
            x_ifv = (done_who == 1) && (done_cyc == cyc);
            x_dv  = (done_who == 2) && (done_cyc == cyc);
            cmp("if_rvalid", 192'(bus.if_rvalid), 192'(x_ifv));
            cmp("d_rvalid",  192'(bus.d_rvalid),  192'(x_dv));
            if (x_ifv && if_exp.size() > 0) cmp("if_rdata", 192'(bus.if_rdata), 192'(if_exp.pop_front()));
            else                            cmp("if_rdata_idle", 192'(bus.if_rdata), 192'(0));
            if (x_dv && d_exp.size() > 0)   cmp("d_rdata", 192'(bus.d_rdata), 192'(d_exp.pop_front()));
            else                            cmp("d_rdata_idle", 192'(bus.d_rdata), 192'(0));
            if (done_cyc == cyc) done_who = 0;

            e_if = (cyc >= free_cyc) && bus.if_req && (!bus.d_req || starve == SL);
            e_d  = (cyc >= free_cyc) && bus.d_req && !e_if;
            cmp("gnt", 192'({bus.if_gnt, bus.d_gnt}), 192'({e_if, e_d}));
            cmp("mem_req", 192'(bus.mem_req), 192'(e_if || e_d));
            if (e_d) begin
                cmp("mem_we_d",    192'(bus.mem_we),    192'(bus.d_we));
                cmp("mem_addr_d",  192'(bus.mem_addr),  192'(bus.d_addr));
                cmp("mem_wdata_d", 192'(bus.mem_wdata), 192'(bus.d_wdata));
                cmp("mem_wstrb_d", 192'(bus.mem_wstrb), 192'(bus.d_we ? bus.d_wstrb : '0));
            end
            if (e_if) begin
                cmp("mem_we_if",    192'(bus.mem_we),    192'(0));
                cmp("mem_addr_if",  192'(bus.mem_addr),  192'(bus.if_addr));
                cmp("mem_wstrb_if", 192'(bus.mem_wstrb), 192'(0));
            end
            if (e_if || e_d) begin
                free_cyc = cyc + LAT;
                done_cyc = cyc + LAT;
                done_who = e_if ? 1 : 2;
                g_cyc.push_back(cyc);
                g_who.push_back(done_who);
            end
            if (e_if)     starve = 0;
            else if (e_d) starve = bus.if_req ? ((starve < SL) ? starve + 1 : SL) : 0;
        end
    end

    property p_if_hold;
        @(posedge clk) disable iff (!rst) (bus.if_req && !bus.if_gnt) |=> bus.if_req;
    endproperty
    property p_d_hold;
        @(posedge clk) disable iff (!rst) (bus.d_req && !bus.d_gnt) |=> bus.d_req;
    endproperty
    a_if_hold: assert property (p_if_hold) else $error("if_req dropped before grant");
    a_d_hold:  assert property (p_d_hold)  else $error("d_req dropped before grant");

    int exp_who [6] = '{2, 2, 2, 2, 1, 2};

    initial begin
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wstrb = '0;

        // Reset with both requesters waiting; first grant lands right after release.
        if_todo.push_back(32'h0000_0040);
        d_todo.push_back(mk_d(1'b0, 32'h0000_0080, 32'h0, 4'h0));
        repeat (3) drive_cycle();
        rst = 1'b1;
        @(negedge clk); #1;
        cmp("gnt_after_release", 192'(bus.if_gnt || bus.d_gnt), 192'(1));
        drain("reset");

        // Single fetch.
        g_cyc.delete(); g_who.delete();
        if_todo.push_back(32'h0000_0010);
        drain("single_fetch");
        cmp("single_fetch_grants", 192'(g_who.size()), 192'(1));
        if (g_who.size() > 0) cmp("single_fetch_owner", 192'(g_who[0]), 192'(1));

        // Store then load at the same address.
        d_todo.push_back(mk_d(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b0011));
        d_todo.push_back(mk_d(1'b0, 32'h0000_0100, 32'h0, 4'hF));
        drain("store_load");

        // Contention: both requesting continuously.
        g_cyc.delete(); g_who.delete();
        for (int i = 0; i < 6; i++) d_todo.push_back(mk_d(1'(i), 32'h200 + 32'(4 * i), $urandom, 4'hF));
        if_todo.push_back(32'h0000_0300);
        if_todo.push_back(32'h0000_0304);
        drain("contention");
        cmp("contention_grants", 192'(g_who.size() >= 6), 192'(1));
        for (int i = 0; i < 6 && i < g_who.size(); i++) begin
            cmp($sformatf("contention_who%0d", i), 192'(g_who[i]), 192'(exp_who[i]));
            cmp($sformatf("contention_cyc%0d", i), 192'(g_cyc[i] - g_cyc[0]), 192'(2 * i));
        end

        // Back-to-back fetches.
        g_cyc.delete(); g_who.delete();
        for (int i = 0; i < 8; i++) if_todo.push_back(32'h1000 + 32'(4 * i));
        drain("b2b_if");
        cmp("b2b_grants", 192'(g_who.size()), 192'(8));
        for (int i = 1; i < 8 && i < g_cyc.size(); i++)
            cmp($sformatf("b2b_spacing%0d", i), 192'(g_cyc[i] - g_cyc[i-1]), 192'(LAT));

        // Reset one cycle into a D load; its response must never appear.
        d_todo.push_back(mk_d(1'b0, 32'h0000_0500, 32'h0, 4'hF));
        for (int n = 0; n < 20 && !d_gnt_seen; n++) drive_cycle();
        cmp("abort_load_granted", 192'(d_gnt_seen), 192'(1));
        drive_cycle();
        rst = 1'b0;
        repeat (2) drive_cycle();
        rst = 1'b1;
        cmp("abort_queue_dropped", 192'(d_exp.size()), 192'(0));
        d_todo.push_back(mk_d(1'b0, 32'h0000_0600, 32'h0, 4'hF));
        if_todo.push_back(32'h0000_0700);
        drain("after_abort");

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            if (if_todo.size() < 2 && $urandom_range(0, 99) < 40)
                if_todo.push_back($urandom);
            if (d_todo.size() < 2 && $urandom_range(0, 99) < 50)
                d_todo.push_back(mk_d(1'($urandom), $urandom, $urandom, 4'($urandom)));
            drive_cycle();
        end
        drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
